// File: rtl/ocp_multi_timer_if.sv
// OCP slave-port bundle for the multi-channel timer: command, address and write
// data from the master, accept and registered response from the slave.
interface ocp_multi_timer_if;
  logic [2:0]  ocp_mcmd;
  logic [31:0] ocp_maddr;
  logic [31:0] ocp_mdata;
  logic        ocp_scmdaccept;
  logic [1:0]  ocp_sresp;
  logic [31:0] ocp_sdata;

  modport master (
    output ocp_mcmd, ocp_maddr, ocp_mdata,
    input  ocp_scmdaccept, ocp_sresp, ocp_sdata
  );

  modport slave (
    input  ocp_mcmd, ocp_maddr, ocp_mdata,
    output ocp_scmdaccept, ocp_sresp, ocp_sdata
  );
endinterface

// File: rtl/ocp_multi_timer.sv
// NUM_CH independent down-counting timers (one-shot/periodic, sticky expiry,
// level interrupt) behind a single OCP slave port with a one-cycle response.
module ocp_multi_timer #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  ocp_multi_timer_if.slave  ocp,
  output logic [NUM_CH-1:0] irq
);

  localparam logic [2:0]  CMD_IDLE  = 3'b000;
  localparam logic [2:0]  CMD_WR    = 3'b001;
  localparam logic [2:0]  CMD_RD    = 3'b010;
  localparam logic [1:0]  RESP_NULL = 2'b00;
  localparam logic [1:0]  RESP_DVA  = 2'b01;
  localparam logic [1:0]  RESP_ERR  = 2'b11;
  localparam logic [31:0] SPAN      = 32'(16 * NUM_CH);

  logic [WIDTH-1:0]  load_r [NUM_CH];
  logic [WIDTH-1:0]  curr_r [NUM_CH];
  logic [NUM_CH-1:0] en_r;
  logic [NUM_CH-1:0] per_r;
  logic [NUM_CH-1:0] ie_r;
  logic [NUM_CH-1:0] exp_r;
  logic [NUM_CH-1:0] irq_r;
  logic [1:0]        sresp_r;
  logic [31:0]       sdata_r;

  logic [31:0]       offset_s;
  logic [3:0]        ch_s;
  logic [1:0]        sel_s;
  logic              is_wr_s;
  logic              is_rd_s;
  logic              err_s;
  logic              wr_ok_s;
  logic              en_sel_s;
  logic [31:0]       chv_s;
  logic [31:0]       rdata_s;
  logic [WIDTH-1:0]  wdata_s;
  logic [NUM_CH-1:0] wr_ch_s;
  logic [NUM_CH-1:0] expire_s;

  // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
  assign offset_s = ocp.ocp_maddr - BASE_ADDR;
  assign ch_s     = offset_s[7:4];
  assign sel_s    = offset_s[3:2];
  assign wdata_s  = ocp.ocp_mdata[WIDTH-1:0];

  assign ocp.ocp_scmdaccept = (ocp.ocp_mcmd != CMD_IDLE) && reset_n;
  assign ocp.ocp_sresp      = sresp_r;
  assign ocp.ocp_sdata      = sdata_r;
  assign irq                = irq_r;

  // Command decode, error classification, read mux and per-channel strobes
  always_comb begin
    is_wr_s  = (ocp.ocp_mcmd == CMD_WR);
    is_rd_s  = (ocp.ocp_mcmd == CMD_RD);
    en_sel_s = 1'b0;
    rdata_s  = 32'd0;
    chv_s    = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (sel_s)
        2'd0:    chv_s = 32'(load_r[i]);
        2'd1:    chv_s = 32'(curr_r[i]);
        2'd2:    chv_s = {29'd0, ie_r[i], per_r[i], en_r[i]};
        2'd3:    chv_s = {31'd0, exp_r[i]};
        default: chv_s = 32'd0;
      endcase
      en_sel_s    = en_sel_s | ((ch_s == 4'(i)) & en_r[i]);
      rdata_s     = rdata_s | ((ch_s == 4'(i)) ? chv_s : 32'd0);
      expire_s[i] = en_r[i] && (curr_r[i] == {WIDTH{1'b0}});
    end
    if (ocp.ocp_mcmd == CMD_IDLE) begin
      err_s = 1'b0;
    end else if (!(is_wr_s || is_rd_s)) begin
      err_s = 1'b1;
    end else if ((offset_s >= SPAN) || (offset_s[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else if (is_wr_s && (sel_s == 2'd1) && en_sel_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
    wr_ok_s = is_wr_s && !err_s;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ch_s[i] = wr_ok_s && (ch_s == 4'(i));
    end
  end

  // Registered OCP response: exactly one cycle after the accepted command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sresp_r <= RESP_NULL;
      sdata_r <= 32'd0;
    end else begin
      sresp_r <= (ocp.ocp_mcmd == CMD_IDLE) ? RESP_NULL : (err_s ? RESP_ERR : RESP_DVA);
      sdata_r <= (is_rd_s && !err_s) ? rdata_s : 32'd0;
    end
  end

  // Channel state: hardware tick first, software write afterwards so it wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        load_r[i] <= {WIDTH{1'b0}};
        curr_r[i] <= {WIDTH{1'b0}};
      end
      en_r  <= {NUM_CH{1'b0}};
      per_r <= {NUM_CH{1'b0}};
      ie_r  <= {NUM_CH{1'b0}};
      exp_r <= {NUM_CH{1'b0}};
      irq_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        irq_r[i] <= exp_r[i] & ie_r[i];
        if (expire_s[i]) begin
          exp_r[i] <= 1'b1;
          if (per_r[i]) begin
            curr_r[i] <= load_r[i];
          end else begin
            en_r[i] <= 1'b0;
          end
        end else if (en_r[i]) begin
          curr_r[i] <= curr_r[i] - WIDTH'(1'b1);
        end
        if (wr_ch_s[i]) begin
          case (sel_s)
            2'd0: load_r[i] <= wdata_s;
            2'd1: curr_r[i] <= wdata_s;
            2'd2: begin
              en_r[i]  <= ocp.ocp_mdata[0];
              per_r[i] <= ocp.ocp_mdata[1];
              ie_r[i]  <= ocp.ocp_mdata[2];
              // Start reloads; stop freezes CURR at the value seen this cycle.
              if (!en_r[i] && ocp.ocp_mdata[0]) begin
                curr_r[i] <= load_r[i];
              end else if (en_r[i] && !ocp.ocp_mdata[0]) begin
                curr_r[i] <= curr_r[i];
              end
            end
            2'd3: begin
              if (ocp.ocp_mdata[0] && !expire_s[i]) begin
                exp_r[i] <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ocp_multi_timer.sv
// Randomised self-checking bench for ocp_multi_timer: a cycle-level behavioural
// model predicts every response and irq, plus directed literal checks.
module tb_ocp_multi_timer;
  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NCH-1:0] irq;
  logic [0:0]     irq8;

  ocp_multi_timer_if ocp ();
  ocp_multi_timer_if ocp8 ();

  ocp_multi_timer #(.NUM_CH(NCH), .WIDTH(32), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset_n(reset_n), .ocp(ocp.slave), .irq(irq));

  ocp_multi_timer #(.NUM_CH(1), .WIDTH(8), .BASE_ADDR(BASE)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .ocp(ocp8.slave), .irq(irq8));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  // model state
  logic [31:0] m_load [NCH];
  logic [31:0] m_curr [NCH];
  bit m_en [NCH], m_per [NCH], m_ie [NCH], m_exp [NCH], m_irq [NCH];
  logic [1:0]     e_resp = 2'b00;
  logic [31:0]    e_data = 32'd0;
  logic [NCH-1:0] e_irq = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_load[i] = 32'd0; m_curr[i] = 32'd0;
      m_en[i] = 0; m_per[i] = 0; m_ie[i] = 0; m_exp[i] = 0; m_irq[i] = 0;
    end
    e_resp = 2'b00; e_data = 32'd0; e_irq = '0;
  endtask

  // One clock of the timer block, straight from the register-map rules.
  task automatic model_cycle(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                             output logic [1:0] resp, output logic [31:0] rd);
    int ch, rg;
    bit legal, wr_hit, fire;
    logic [31:0] off, old_curr, old_load;
    bit old_en;
    off = addr - BASE;
    resp = 2'b00; rd = 32'd0; ch = 0; rg = 0; wr_hit = 0;
    if (cmd != 3'd0) begin
      legal = (cmd == 3'd1 || cmd == 3'd2) && addr >= BASE && addr < BASE + 32'(16 * NCH)
              && addr[1:0] == 2'b00;
      if (legal) begin ch = int'(off / 32'd16); rg = int'((off % 32'd16) / 32'd4); end
      if (legal && cmd == 3'd1 && rg == 1 && m_en[ch]) legal = 0;
      resp = legal ? 2'b01 : 2'b11;
      if (legal && cmd == 3'd2) begin
        case (rg)
          0: rd = m_load[ch];
          1: rd = m_curr[ch];
          2: rd = {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
          default: rd = {31'd0, m_exp[ch]};
        endcase
      end
      wr_hit = legal && cmd == 3'd1;
    end
    for (int i = 0; i < NCH; i++) begin
      m_irq[i] = m_exp[i] & m_ie[i];
      old_en = m_en[i]; old_curr = m_curr[i]; old_load = m_load[i];
      fire = m_en[i] && m_curr[i] == 32'd0;
      if (fire) begin
        m_exp[i] = 1;
        if (m_per[i]) m_curr[i] = m_load[i];
        else m_en[i] = 0;
      end else if (m_en[i]) begin
        m_curr[i] = m_curr[i] - 32'd1;
      end
      if (wr_hit && ch == i) begin
        case (rg)
          0: m_load[i] = data;
          1: m_curr[i] = data;
          2: begin
            m_en[i] = data[0]; m_per[i] = data[1]; m_ie[i] = data[2];
            if (!old_en && data[0]) m_curr[i] = old_load;
            else if (old_en && !data[0]) m_curr[i] = old_curr;
          end
          default: if (data[0] && !fire) m_exp[i] = 0;
        endcase
      end
    end
  endtask

  task automatic step(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] cmd8 = 3'd0, input logic [31:0] addr8 = 32'd0,
                      input logic [31:0] data8 = 32'd0);
    logic [1:0] r;
    logic [31:0] d;
    @(negedge clk);
    ocp.ocp_mcmd = cmd; ocp.ocp_maddr = addr; ocp.ocp_mdata = data;
    ocp8.ocp_mcmd = cmd8; ocp8.ocp_maddr = addr8; ocp8.ocp_mdata = data8;
    model_cycle(cmd, addr, data, r, d);
    #1 chk("accept", {31'd0, ocp.ocp_scmdaccept}, {31'd0, cmd != 3'd0});
    @(posedge clk);
    #1;
    e_resp = r; e_data = d;
    for (int i = 0; i < NCH; i++) e_irq[i] = m_irq[i];
    ocp.ocp_mcmd = 3'd0; ocp8.ocp_mcmd = 3'd0;
  endtask

  task automatic do_reset();
    chk_on = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    ocp.ocp_mcmd = 3'b010;
    #1;
    chk("rst_accept", {31'd0, ocp.ocp_scmdaccept}, 32'd0);
    chk("rst_sresp", {30'd0, ocp.ocp_sresp}, 32'd0);
    chk("rst_sdata", ocp.ocp_sdata, 32'd0);
    chk("rst_irq", {28'd0, irq}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ocp.ocp_mcmd = 3'd0;
    @(posedge clk);
    #1 chk_on = 1'b1;
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sresp", {30'd0, ocp.ocp_sresp}, {30'd0, e_resp});
      chk("sdata", ocp.ocp_sdata, e_data);
      chk("irq", {28'd0, irq}, {28'd0, e_irq});
    end
  end

  initial begin
    logic [2:0]  cmd;
    logic [31:0] addr, data;
    int r, ch, rg;
    ocp.ocp_mcmd = 3'd0; ocp.ocp_maddr = 32'd0; ocp.ocp_mdata = 32'd0;
    ocp8.ocp_mcmd = 3'd0; ocp8.ocp_maddr = 32'd0; ocp8.ocp_mdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 chk_on = 1'b1;

    // ch0 counting from 20; after 15 idle cycles CURR is 5, then reset mid-count
    step(3'd1, BASE + 32'h0, 32'd20);
    step(3'd1, BASE + 32'h8, 32'd1);
    repeat (15) step(3'd0, 32'd0, 32'd0);
    step(3'd2, BASE + 32'h4, 32'd0);
    chk("ch0_curr_5", ocp.ocp_sdata, 32'd5);
    do_reset();
    step(3'd2, BASE + 32'h4, 32'd0);
    chk("rst_curr_resp", {30'd0, ocp.ocp_sresp}, 32'd1);
    chk("rst_curr_data", ocp.ocp_sdata, 32'd0);

    // ch0 runs periodically for the rest of the run
    step(3'd1, BASE + 32'h0, 32'd1000);
    step(3'd1, BASE + 32'h8, 32'd3);

    // one-shot on ch1
    step(3'd1, BASE + 32'h10, 32'd3);
    step(3'd1, BASE + 32'h18, 32'd5);
    for (int k = 0; k < 4; k++) begin
      step(3'd2, BASE + 32'h14, 32'd0);
      chk("oneshot_curr", ocp.ocp_sdata, 32'(3 - k));
    end
    step(3'd0, 32'd0, 32'd0);
    chk("oneshot_irq", {31'd0, irq[1]}, 32'd1);
    step(3'd2, BASE + 32'h18, 32'd0);
    chk("oneshot_ctrl", ocp.ocp_sdata, 32'h4);
    step(3'd1, BASE + 32'h1C, 32'd1);
    step(3'd0, 32'd0, 32'd0);
    chk("oneshot_irq_clr", {31'd0, irq[1]}, 32'd0);

    // periodic on ch2 without interrupt
    step(3'd1, BASE + 32'h20, 32'd2);
    step(3'd1, BASE + 32'h28, 32'd3);
    for (int k = 0; k < 6; k++) begin
      step(3'd2, BASE + 32'h24, 32'd0);
      chk("periodic_curr", ocp.ocp_sdata, 32'(2 - (k % 3)));
    end
    step(3'd2, BASE + 32'h2C, 32'd0);
    chk("periodic_status", ocp.ocp_sdata, 32'd1);
    chk("periodic_irq", {31'd0, irq[2]}, 32'd0);

    // error responses
    step(3'd2, BASE + 32'h40, 32'd0);
    chk("err_range", {30'd0, ocp.ocp_sresp}, 32'd3);
    step(3'd2, BASE + 32'h2, 32'd0);
    chk("err_align", {30'd0, ocp.ocp_sresp}, 32'd3);
    step(3'd7, BASE, 32'd0);
    chk("err_cmd", {30'd0, ocp.ocp_sresp}, 32'd3);
    step(3'd1, BASE + 32'h4, 32'hDEAD);
    chk("err_curr_wr", {30'd0, ocp.ocp_sresp}, 32'd3);
    chk("err_curr_data", ocp.ocp_sdata, 32'd0);

    // expiry vs W1C on ch3: set wins
    step(3'd1, BASE + 32'h30, 32'd0);
    step(3'd1, BASE + 32'h38, 32'd3);
    step(3'd1, BASE + 32'h3C, 32'd1);
    step(3'd2, BASE + 32'h3C, 32'd0);
    chk("contention_exp", ocp.ocp_sdata, 32'd1);

    // back-to-back write then read
    step(3'd1, BASE + 32'h10, 32'd7);
    chk("b2b_wr", {30'd0, ocp.ocp_sresp}, 32'd1);
    step(3'd2, BASE + 32'h10, 32'd0);
    chk("b2b_rd", ocp.ocp_sdata, 32'd7);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      ch = $urandom_range(0, NCH - 1);
      rg = $urandom_range(0, 3);
      cmd = (r < 25) ? 3'd0 : (r < 60) ? 3'd2 : (r < 95) ? 3'd1 : 3'($urandom_range(3, 7));
      addr = BASE + 32'(16 * ch + 4 * rg);
      r = $urandom_range(0, 99);
      if (r < 4) addr = BASE + 32'(16 * NCH) + 32'($urandom_range(0, 64));
      else if (r < 7) addr = BASE - 32'd4;
      else if (r < 11) addr = addr + 32'($urandom_range(1, 3));
      case (rg)
        0, 1:    data = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 9));
        2:       data = 32'($urandom_range(0, 7));
        default: data = 32'($urandom_range(0, 1));
      endcase
      step(cmd, addr, data);
    end

    // 8-bit counter instance: writes truncate, reads zero-extend
    step(3'd0, 32'd0, 32'd0, 3'd1, BASE, 32'h1FF);
    step(3'd0, 32'd0, 32'd0, 3'd2, BASE, 32'd0);
    chk("w8_load_resp", {30'd0, ocp8.ocp_sresp}, 32'd1);
    chk("w8_load_data", ocp8.ocp_sdata, 32'h0000_00FF);
    step(3'd0, 32'd0, 32'd0, 3'd2, BASE + 32'h10, 32'd0);
    chk("w8_range", {30'd0, ocp8.ocp_sresp}, 32'd3);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ocp_multi_timer.md
Name: ocp_multi_timer

Overview:
Parametrised successor to the single-channel OCP PIO timer. It provides NUM_CH independent down-counting timers behind one OCP slave port. Each channel supports one-shot or periodic mode, a sticky expiry flag and an interrupt line. It sits on the peripheral OCP bus next to the other PIO slaves and drives per-channel interrupts to the interrupt controller.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
WIDTH, 32, counter width in bits (1..32)
BASE_ADDR, 32'h4000_0000, byte address of channel 0; channel n occupies BASE_ADDR + 16*n

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
ocp_mcmd  input  3  OCP MCmd: 3'b000 IDLE, 3'b001 WR, 3'b010 RD, others illegal
ocp_maddr  input  32  OCP byte address
ocp_mdata  input  32  OCP write data
ocp_scmdaccept  output  1  command accept
ocp_sresp  output  2  OCP SResp: 2'b00 NULL, 2'b01 DVA, 2'b11 ERR
ocp_sdata  output  32  read data, valid while ocp_sresp != NULL
irq  output  NUM_CH  per-channel interrupt, level-high

Behaviour:
- Reset (async, reset_n=0): all registers 0; ocp_sresp=NULL, ocp_sdata=0, irq=0. ocp_scmdaccept is held 0 while reset_n=0.
- Per-channel register map, offset from the channel base:
  - 0x0 LOAD (RW, WIDTH bits).
  - 0x4 CURR (RW).
  - 0x8 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IRQ_EN.
  - 0xC STATUS (RW1C): bit0 EXPIRED.
- Reads zero-extend to 32 bits. Writes truncate to WIDTH bits. Undefined CTRL/STATUS bits read 0.
- Handshake:
  - ocp_scmdaccept=1 combinationally whenever ocp_mcmd != IDLE and reset_n=1. Every command is accepted in the cycle it is presented.
  - The response is registered: ocp_sresp/ocp_sdata are valid for exactly one cycle, the cycle after accept. Otherwise ocp_sresp=NULL and ocp_sdata=0.
  - Back-to-back commands are supported with one response per cycle.
- ERR response (no state change, ocp_sdata=0) for any of:
  - address outside BASE_ADDR .. BASE_ADDR+16*NUM_CH-1;
  - address bits [1:0] != 0;
  - illegal MCmd;
  - write to CURR while EN=1.
- Counter operation per channel, evaluated every cycle when EN=1:
  - CURR != 0: CURR <= CURR-1.
  - CURR == 0: EXPIRED <= 1.
    - PERIODIC=1: CURR <= LOAD.
    - PERIODIC=0: EN <= 0; CURR stays 0.
  - Resulting period is LOAD+1 cycles. LOAD=0 in periodic mode expires every cycle.
- CTRL write with EN 0->1 loads CURR <= LOAD in that edge; counting starts the next cycle.
- CTRL write with EN 1->1 does not reload. It may change PERIODIC/IRQ_EN on the fly.
- CTRL write with EN 1->0 freezes CURR at its current value.
- LOAD write while running: CURR is unaffected; the new value is used at the next reload or enable.
- CURR reads are legal in any state and return the value before that cycle's update.
- irq[n] is registered: irq[n] <= EXPIRED[n] & IRQ_EN[n].
- Simultaneous events:
  - hardware expiry and STATUS W1C in the same cycle: set wins, EXPIRED stays 1.
  - CTRL write and hardware auto-disable in the same cycle: the software write wins.
- Channels are fully independent. A bus access to channel n never perturbs channel m.

Test Plan:
- Reset: assert reset_n=0 mid-count (ch0 CURR=5) -> all regs 0 and irq=0 immediately; after release, RD CURR ch0 returns DVA 0.
- One-shot: ch1 WR LOAD=3, WR CTRL=0x5 -> CURR reads 3,2,1,0 on successive cycles. Then EXPIRED=1, EN=0, irq[1]=1 one cycle later. WR STATUS=1 -> irq[1]=0 the following cycle.
- Periodic: ch2 LOAD=2, CTRL=0x3 -> EXPIRED set every 3 cycles and CURR sequence 2,1,0,2,1,0. With IRQ_EN=0, irq[2] stays 0.
- Errors: RD 0x4000_0040 (NUM_CH=4), RD 0x4000_0002, MCmd=3'b111, WR CURR ch0 while EN=1 -> each gives ERR with ocp_sdata=0 and no register change.
- Contention: ch3 LOAD=0 periodic, WR STATUS=1 on an expiry cycle -> EXPIRED still 1. Independence: ch0 counts undisturbed throughout ch3 traffic.
- Width: WIDTH=8, WR LOAD=0x1FF -> RD LOAD returns 0x000000FF. Back-to-back RD/WR on consecutive cycles -> one DVA per cycle in order.
